// File: rtl/reg_list_sequencer.sv
// Load/store-multiple register-list sequencer: one register index and address per handshake.
// Optional macro REGSEQ_DESCEND_EN adds a dir input for highest-bit-first order with decrementing addresses.
module reg_list_sequencer #(
  parameter int MASK_W = 8,
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MASK_W-1:0] mask,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef REGSEQ_DESCEND_EN
  input  logic              dir,
`endif
  input  logic              ready,
  output logic              valid,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    count,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a transfer moves on a rising edge where valid & ready; valid stays up until then.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [MASK_W-1:0]   rem_q;
  logic [MASK_W-1:0]   rem_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [IDX_W:0]      count_q;
  logic                first_q;
  int                  sel_int;
`ifdef REGSEQ_DESCEND_EN
  logic                dir_q;
`endif

  // Pick the next bit to transfer and the list that remains once it is accepted.
  always_comb begin
    sel_int = 0;
    rem_d   = '0;
`ifdef REGSEQ_DESCEND_EN
    if (dir_q) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (rem_q[i]) sel_int = i;
      end
      for (int j = 0; j < MASK_W; j++) begin
        rem_d[j] = rem_q[j] && (j < sel_int);
      end
      addr_d = addr_q - ADDR_W'(1);
    end else begin
      for (int i = MASK_W - 1; i >= 0; i--) begin
        if (rem_q[i]) sel_int = i;
      end
      for (int j = 0; j < MASK_W; j++) begin
        rem_d[j] = rem_q[j] && (j > sel_int);
      end
      addr_d = addr_q + ADDR_W'(1);
    end
`else
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (rem_q[i]) sel_int = i;
    end
    for (int j = 0; j < MASK_W; j++) begin
      rem_d[j] = rem_q[j] && (j > sel_int);
    end
    addr_d = addr_q + ADDR_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      first_q <= 1'b0;
`ifdef REGSEQ_DESCEND_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q   <= mask;
            count_q <= '0;
            if (mask != '0) begin
              addr_q  <= base_addr;
              first_q <= 1'b1;
`ifdef REGSEQ_DESCEND_EN
              dir_q   <= dir;
`endif
              state_q <= S_RUN;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (ready) begin
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            count_q <= count_q + (IDX_W+1)'(1);
            first_q <= 1'b0;
            if (rem_d == '0) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Everything below decodes registers only; rem_q is zero outside RUN, so idx/last read 0 there.
  assign valid       = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign idx         = sel_int[IDX_W-1:0];
  assign last        = (rem_q != '0) && ((rem_q & (rem_q - MASK_W'(1))) == '0);
  assign addr        = addr_q;
  assign first       = first_q;
  assign count       = count_q;
  assign dbg_state_o = state_q;

endmodule
